// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: register offsets, bus FSM states and the
// default input count used by both the switch/button and LED paths.
package board_io_pkg;

    localparam int BOARD_N_IO = 10;

    localparam logic [3:0] BIN_STATE_OFS = 4'h0;
    localparam logic [3:0] BIN_RISE_OFS  = 4'h4;
    localparam logic [3:0] BIN_FALL_OFS  = 4'h8;
    localparam logic [3:0] BIN_MASK_OFS  = 4'hC;

    typedef enum logic {
        IDLE,
        RESP
    } bus_state_t;

endpackage

// File: rtl/input_debouncer.sv
// One board input: 2-flop synchronizer, hold-time debouncer and a one-cycle
// rise/fall pulse coincident with the stable level changing.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic stb,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    // NOTE: non-blocking assignments keep the two stages as two distinct flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
        end
    end

    assign accept = (sync2 != stb) && (cnt == CNT_MAX);

    // The counter restarts whenever the synced level falls back to stb,
    // so any excursion shorter than DEBOUNCE_CYCLES is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            stb <= 1'b0;
        end else if (sync2 == stb) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
            stb <= sync2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign rise = accept & sync2;
    assign fall = accept & ~sync2;

endmodule

// File: rtl/board_input_port.sv
// Memory-mapped board switch/button input port with sticky edge flags.
// Optional interrupt mask and irq output are built when BOARD_IN_IRQ_EN is defined.
module board_input_port
    import board_io_pkg::*;
#(
    parameter int N_IN            = BOARD_N_IO,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] sw_in,
    input  logic            bus_req,
    input  logic            bus_we,
    input  logic [3:0]      bus_addr,
    input  logic [31:0]     bus_wdata,
    output logic [31:0]     bus_rdata,
    output logic            bus_ack,
    output logic            bus_err
`ifdef BOARD_IN_IRQ_EN
    ,
    output logic            irq
`endif
);

    bus_state_t      state;
    bus_state_t      next_state;
    logic [N_IN-1:0] stb_v;
    logic [N_IN-1:0] rise_p;
    logic [N_IN-1:0] fall_p;
    logic [N_IN-1:0] rise_q;
    logic [N_IN-1:0] fall_q;
    logic [N_IN-1:0] clr_rise;
    logic [N_IN-1:0] clr_fall;
    logic [31:0]     rdata_d;
    logic            ack_d;
    logic            err_d;
    logic            unused_wdata;
`ifdef BOARD_IN_IRQ_EN
    logic [N_IN-1:0] mask_q;
    logic            mask_we;
`endif

    assign unused_wdata = ^bus_wdata;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .sw_in(sw_in[i]),
            .stb  (stb_v[i]),
            .rise (rise_p[i]),
            .fall (fall_p[i])
        );
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = '0;
        clr_rise   = '0;
        clr_fall   = '0;
`ifdef BOARD_IN_IRQ_EN
        mask_we    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus_req) begin
                    next_state = RESP;
                    if (bus_addr[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        case (bus_addr)
                            BIN_STATE_OFS: begin
                                if (bus_we) err_d = 1'b1;
                                else begin
                                    ack_d   = 1'b1;
                                    rdata_d = 32'(stb_v);
                                end
                            end
                            BIN_RISE_OFS: begin
                                ack_d = 1'b1;
                                if (bus_we) clr_rise = bus_wdata[N_IN-1:0];
                                else        rdata_d  = 32'(rise_q);
                            end
                            BIN_FALL_OFS: begin
                                ack_d = 1'b1;
                                if (bus_we) clr_fall = bus_wdata[N_IN-1:0];
                                else        rdata_d  = 32'(fall_q);
                            end
                            BIN_MASK_OFS: begin
                                ack_d = 1'b1;
`ifdef BOARD_IN_IRQ_EN
                                if (bus_we) mask_we = 1'b1;
                                else        rdata_d = 32'(mask_q);
`endif
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A new edge outranks a simultaneous write-1-to-clear on the same bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus_ack   <= 1'b0;
            bus_err   <= 1'b0;
            bus_rdata <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
        end else begin
            state     <= next_state;
            bus_ack   <= ack_d;
            bus_err   <= err_d;
            bus_rdata <= rdata_d;
            rise_q    <= (rise_q & ~clr_rise) | rise_p;
            fall_q    <= (fall_q & ~clr_fall) | fall_p;
        end
    end

`ifdef BOARD_IN_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= '0;
            irq    <= 1'b0;
        end else begin
            if (mask_we) mask_q <= bus_wdata[N_IN-1:0];
            irq <= |((rise_q | fall_q) & mask_q);
        end
    end
`endif

endmodule

// File: tb/tb_board_input_port.sv
// Self-checking bench for board_input_port with DEBOUNCE_CYCLES=4; irq checks
// are compiled in when BOARD_IN_IRQ_EN is defined.
module tb_board_input_port;

    localparam int N = 10;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  sw_in;
    logic          bus_req;
    logic          bus_we;
    logic [3:0]    bus_addr;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;
    logic          bus_ack;
    logic          bus_err;
`ifdef BOARD_IN_IRQ_EN
    logic          irq;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    board_input_port #(
        .N_IN(N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_in    (sw_in),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err)
`ifdef BOARD_IN_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    // Reference model: a level is accepted once the synchronized input (raw
    // input two cycles late) has shown the opposite value for D straight cycles.
    logic [N-1:0] hist [0:D];
    logic [N-1:0] m_stb, m_rise, m_fall, m_next;
    logic [N-1:0] m_clr_rise = '0;
    logic [N-1:0] m_clr_fall = '0;
`ifdef BOARD_IN_IRQ_EN
    logic [N-1:0] m_mask;
    logic [N-1:0] m_mask_d = '0;
    logic         m_mask_we = 1'b0;
    logic         m_irq;
`endif

    function automatic logic [N-1:0] settle(input logic [N-1:0] h [0:D], input logic [N-1:0] cur);
        logic [N-1:0] res;
        logic         other;
        res = cur;
        for (int i = 0; i < N; i++) begin
            other = 1'b1;
            for (int k = 1; k <= D; k++)
                if (h[k][i] == cur[i]) other = 1'b0;
            if (other) res[i] = ~cur[i];
        end
        return res;
    endfunction

    always_comb m_next = settle(hist, m_stb);

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k <= D; k++) hist[k] <= '0;
            m_stb  <= '0;
            m_rise <= '0;
            m_fall <= '0;
        end else begin
            hist[0] <= sw_in;
            for (int k = 1; k <= D; k++) hist[k] <= hist[k-1];
            m_stb  <= m_next;
            m_rise <= (m_rise & ~m_clr_rise) | (m_next & ~m_stb);
            m_fall <= (m_fall & ~m_clr_fall) | (~m_next & m_stb);
        end
    end

`ifdef BOARD_IN_IRQ_EN
    always @(posedge clk) begin
        if (!rst_n) begin
            m_mask <= '0;
            m_irq  <= 1'b0;
        end else begin
            if (m_mask_we) m_mask <= m_mask_d;
            m_irq <= |((m_rise | m_fall) & m_mask);
        end
    end
`endif

    // One bus transaction; ex is the model's view of the addressed register
    // as it stands in the cycle the request is accepted.
    task automatic bus_access(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic ack, output logic err,
                              output logic [31:0] ex);
        @(negedge clk);
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        if (we && addr == 4'h4) m_clr_rise = wd[N-1:0];
        if (we && addr == 4'h8) m_clr_fall = wd[N-1:0];
`ifdef BOARD_IN_IRQ_EN
        if (we && addr == 4'hC) begin
            m_mask_we = 1'b1;
            m_mask_d  = wd[N-1:0];
        end
`endif
        case (addr)
            4'h0:    ex = 32'(m_stb);
            4'h4:    ex = 32'(m_rise);
            4'h8:    ex = 32'(m_fall);
`ifdef BOARD_IN_IRQ_EN
            4'hC:    ex = 32'(m_mask);
`endif
            default: ex = 32'h0;
        endcase
        @(negedge clk);
        rd  = bus_rdata;
        ack = bus_ack;
        err = bus_err;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        m_clr_rise = '0;
        m_clr_fall = '0;
`ifdef BOARD_IN_IRQ_EN
        m_mask_we  = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [31:0] rd, ex;
        logic ack, err;
        rst_n = 1'b0;
        sw_in = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_ack, bus_err, bus_rdata} !== 34'h0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b err=%b rdata=%h, required 0 0 0", bus_ack, bus_err, bus_rdata);
        end
`ifdef BOARD_IN_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: irq=%b, required 0", irq);
        end
`endif
        rst_n = 1'b1;
        bus_access(1'b0, 4'h0, 32'h0, rd, ack, err, ex);
        checks++;
        if (rd !== 32'h0 || ack !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdata=%h ack=%b err=%b, required 000 1 0", rd, ack, err);
        end
        repeat (6) @(negedge clk);
        bus_access(1'b0, 4'h0, 32'h0, rd, ack, err, ex);
        checks++;
        if (rd !== 32'h3FF || ex !== 32'h3FF || ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_state_settled: rdata=%h model=%h ack=%b, required 3ff", rd, ex, ack);
        end
        bus_access(1'b0, 4'h4, 32'h0, rd, ack, err, ex);
        checks++;
        if (rd !== 32'h3FF || ex !== 32'h3FF || ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_rise: rdata=%h model=%h ack=%b, required 3ff", rd, ex, ack);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] rd, ex;
        logic ack, err;
        sw_in = '0;
        repeat (10) @(negedge clk);
        bus_access(1'b1, 4'h4, 32'h3FF, rd, ack, err, ex);
        bus_access(1'b1, 4'h8, 32'h3FF, rd, ack, err, ex);
        sw_in[3] = 1'b1;
        repeat (3) @(negedge clk);
        sw_in[3] = 1'b0;
        repeat (10) @(negedge clk);
        bus_access(1'b0, 4'h0, 32'h0, rd, ack, err, ex);
        checks++;
        if (rd !== 32'h0 || ex !== 32'h0) begin
            errors++;
            $display("FAIL glitch_state: rdata=%h model=%h, required 000", rd, ex);
        end
        bus_access(1'b0, 4'h4, 32'h0, rd, ack, err, ex);
        checks++;
        if (rd !== 32'h0 || ex !== 32'h0) begin
            errors++;
            $display("FAIL glitch_rise: rdata=%h model=%h, required 000", rd, ex);
        end
    endtask

    task automatic test_edges_w1c();
        logic [31:0] rd, ex;
        logic ack, err;
        sw_in[3] = 1'b1;
        repeat (10) @(negedge clk);
        sw_in[3] = 1'b0;
        repeat (10) @(negedge clk);
        bus_access(1'b0, 4'h4, 32'h0, rd, ack, err, ex);
        checks++;
        if (rd !== 32'h008 || ex !== 32'h008) begin
            errors++;
            $display("FAIL edge_rise: rdata=%h model=%h, required 008", rd, ex);
        end
        bus_access(1'b0, 4'h8, 32'h0, rd, ack, err, ex);
        checks++;
        if (rd !== 32'h008 || ex !== 32'h008) begin
            errors++;
            $display("FAIL edge_fall: rdata=%h model=%h, required 008", rd, ex);
        end
        bus_access(1'b1, 4'h4, 32'h008, rd, ack, err, ex);
        checks++;
        if (ack !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL w1c_ack: ack=%b err=%b, required 1 0", ack, err);
        end
        bus_access(1'b0, 4'h4, 32'h0, rd, ack, err, ex);
        checks++;
        if (rd !== 32'h0 || ex !== 32'h0) begin
            errors++;
            $display("FAIL w1c_rise_cleared: rdata=%h model=%h, required 000", rd, ex);
        end
        bus_access(1'b0, 4'h8, 32'h0, rd, ack, err, ex);
        checks++;
        if (rd !== 32'h008 || ex !== 32'h008) begin
            errors++;
            $display("FAIL w1c_fall_kept: rdata=%h model=%h, required 008", rd, ex);
        end
        // Time the clear so it is accepted on the edge where bit 5 becomes stable high.
        sw_in[5] = 1'b1;
        repeat (D) @(negedge clk);
        bus_access(1'b1, 4'h4, 32'h020, rd, ack, err, ex);
        bus_access(1'b0, 4'h4, 32'h0, rd, ack, err, ex);
        checks++;
        if (rd !== 32'h020 || ex !== 32'h020) begin
            errors++;
            $display("FAIL set_beats_clear: rdata=%h model=%h, required 020", rd, ex);
        end
    endtask

    task automatic test_bus_errors();
        logic [31:0] rd, ex;
        logic ack, err;
        bus_access(1'b0, 4'h2, 32'h0, rd, ack, err, ex);
        checks++;
        if (err !== 1'b1 || ack !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_misaligned_read: err=%b ack=%b rdata=%h, required 1 0 0", err, ack, rd);
        end
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0 || bus_ack !== 1'b0 || bus_rdata !== 32'h0) begin
            errors++;
            $display("FAIL err_one_cycle: err=%b ack=%b rdata=%h, required 0 0 0", bus_err, bus_ack, bus_rdata);
        end
        bus_access(1'b1, 4'h0, 32'h3FF, rd, ack, err, ex);
        checks++;
        if (err !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL err_state_write: err=%b ack=%b, required 1 0", err, ack);
        end
        bus_access(1'b1, 4'h5, 32'h020, rd, ack, err, ex);
        bus_access(1'b0, 4'h4, 32'h0, rd, ack, err, ex);
        checks++;
        if (rd !== 32'h020 || ex !== 32'h020) begin
            errors++;
            $display("FAIL err_no_side_effect: rise=%h model=%h, required 020", rd, ex);
        end
        bus_access(1'b0, 4'h0, 32'h0, rd, ack, err, ex);
        checks++;
        if (ack !== 1'b1 || err !== 1'b0 || rd !== ex) begin
            errors++;
            $display("FAIL ok_state_read: ack=%b err=%b rdata=%h, required 1 0 %h", ack, err, rd, ex);
        end
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b0 || bus_rdata !== 32'h0) begin
            errors++;
            $display("FAIL ack_one_cycle: ack=%b rdata=%h, required 0 0", bus_ack, bus_rdata);
        end
        bus_access(1'b1, 4'hC, 32'h0F0, rd, ack, err, ex);
        bus_access(1'b0, 4'hC, 32'h0, rd, ack, err, ex);
        checks++;
        if (ack !== 1'b1 || err !== 1'b0 || rd !== ex) begin
            errors++;
            $display("FAIL mask_access: ack=%b err=%b rdata=%h, required 1 0 %h", ack, err, rd, ex);
        end
        bus_access(1'b1, 4'hC, 32'h0, rd, ack, err, ex);
    endtask

    task automatic test_random();
        logic [31:0] rd, ex;
        logic [3:0]  addr;
        logic ack, err;
        int op;
        for (int it = 0; it < 80; it++) begin
            sw_in = sw_in ^ N'($urandom_range(0, (1 << N) - 1) & $urandom_range(0, (1 << N) - 1));
            repeat ($urandom_range(1, 7)) @(negedge clk);
            op = $urandom_range(0, 5);
            if (op <= 2) begin
                addr = 4'(op * 4);
                bus_access(1'b0, addr, 32'h0, rd, ack, err, ex);
                checks++;
                if (rd !== ex || ack !== 1'b1 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL random_read[%0d] addr %h: rdata=%h ack=%b err=%b, required %h 1 0", it, addr, rd, ack, err, ex);
                end
            end else if (op <= 4) begin
                addr = (op == 3) ? 4'h4 : 4'h8;
                bus_access(1'b1, addr, $urandom, rd, ack, err, ex);
                checks++;
                if (ack !== 1'b1 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL random_w1c[%0d] addr %h: ack=%b err=%b, required 1 0", it, addr, ack, err);
                end
            end else begin
                addr = 4'($urandom_range(0, 3) * 4 + $urandom_range(1, 3));
                bus_access($urandom_range(0, 1) == 1, addr, $urandom, rd, ack, err, ex);
                checks++;
                if (ack !== 1'b0 || err !== 1'b1) begin
                    errors++;
                    $display("FAIL random_err[%0d] addr %h: ack=%b err=%b, required 0 1", it, addr, ack, err);
                end
            end
        end
        repeat (12) @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            addr = 4'(r * 4);
            bus_access(1'b0, addr, 32'h0, rd, ack, err, ex);
            checks++;
            if (rd !== ex || ack !== 1'b1) begin
                errors++;
                $display("FAIL random_final addr %h: rdata=%h ack=%b, required %h 1", addr, rd, ack, ex);
            end
        end
    endtask

`ifdef BOARD_IN_IRQ_EN
    task automatic test_irq();
        logic [31:0] rd, ex;
        logic ack, err;
        sw_in = '0;
        repeat (12) @(negedge clk);
        bus_access(1'b1, 4'h4, 32'h3FF, rd, ack, err, ex);
        bus_access(1'b1, 4'h8, 32'h3FF, rd, ack, err, ex);
        bus_access(1'b1, 4'hC, 32'h001, rd, ack, err, ex);
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b0 || m_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_idle: irq=%b model=%b, required 0", irq, m_irq);
        end
        sw_in[0] = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (irq !== 1'b1 || m_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: irq=%b model=%b, required 1", irq, m_irq);
        end
        bus_access(1'b1, 4'h4, 32'h001, rd, ack, err, ex);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_clear_latency: irq=%b, required 1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0 || m_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_cleared: irq=%b model=%b, required 0", irq, m_irq);
        end
    endtask
`endif

    task automatic test_reset_mid_access();
        logic [31:0] rd, ex;
        logic ack, err;
        @(negedge clk);
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 4'h0;
        rst_n    = 1'b0;
        @(negedge clk);
        bus_req = 1'b0;
        checks++;
        if ({bus_ack, bus_err, bus_rdata} !== 34'h0) begin
            errors++;
            $display("FAIL midreset_outputs: ack=%b err=%b rdata=%h, required 0 0 0", bus_ack, bus_err, bus_rdata);
        end
`ifdef BOARD_IN_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL midreset_irq: irq=%b, required 0", irq);
        end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_ack !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_ack: ack=%b err=%b, required 0 0", bus_ack, bus_err);
        end
        bus_access(1'b0, 4'h4, 32'h0, rd, ack, err, ex);
        checks++;
        if (rd !== 32'h0 || ex !== 32'h0 || ack !== 1'b1) begin
            errors++;
            $display("FAIL midreset_rise: rdata=%h model=%h ack=%b, required 000 1", rd, ex, ack);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sw_in     = '0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 4'h0;
        bus_wdata = 32'h0;
        test_reset();
        test_glitch();
        test_edges_w1c();
        test_bus_errors();
        test_random();
`ifdef BOARD_IN_IRQ_EN
        test_irq();
`endif
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
